pixel_msg_gen: RTL and testbench

//  Parametrised successor to the fixed end-of-game banner: renders one of four stored

---
 rtl/pixel_msg_pkg.sv | 58 +++++
 rtl/ascii_rom.sv | 24 ++
 rtl/pixel_msg_anim.sv | 127 ++++++++++++
 rtl/pixel_msg_gen.sv | 138 +++++++++++++
 tb/tb_pixel_msg_gen.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_msg_pkg.sv
// Shared types, constants, message table and font contents for pixel_msg_gen.
package pixel_msg_pkg;

   // Animation state
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REVEAL = 2'd1,
      SHOW   = 2'd2
   } state_e;

   // Default colours (12-bit RGB, 4 bits per channel)
   localparam logic [11:0] DEF_FG_RGB = 12'h00F;
   localparam logic [11:0] DEF_BG_RGB = 12'hFFF;
   localparam logic [11:0] DEF_CHK_A  = 12'h0F0;
   localparam logic [11:0] DEF_CHK_B  = 12'h000;

   // Font geometry and ROM shape: address = {ascii[6:0], row[3:0]}
   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;
   localparam int ROM_AW  = 11;
   localparam int ROM_DW  = 8;

   // Message table: 4 messages x 8 characters, space-padded, first character in the MSBs
   localparam logic [63:0] MSG_TABLE [4] = '{"WIN!    ", "LOSE    ", "PAUSE   ", "READY   "};

   // 7-bit ASCII code of character idx of message sel
   function automatic logic [6:0] msg_char(input logic [1:0] sel, input logic [2:0] idx);
      logic [63:0] s;
      logic [7:0]  b;
      s = MSG_TABLE[sel];
      b = s[8*(7-int'(idx)) +: 8];
      return b[6:0];
   endfunction

   // One 8-pixel glyph row, leftmost pixel in bit 7; only the characters used by MSG_TABLE are populated
   function automatic logic [7:0] glyph_row(input logic [6:0] c, input logic [3:0] row);
      logic [127:0] g;
      case (c)
         7'h57:   g = 128'h0000C6C6C6C6C6D6D6FEEEC6C6000000; // W
         7'h49:   g = 128'h00003C1818181818181818183C000000; // I
         7'h4E:   g = 128'h0000C6E6E6F6F6DEDECECEC6C6000000; // N
         7'h21:   g = 128'h00001818181818181800001818000000; // !
         7'h4C:   g = 128'h0000C0C0C0C0C0C0C0C0C0C0FE000000; // L
         7'h4F:   g = 128'h00007CC6C6C6C6C6C6C6C6C67C000000; // O
         7'h53:   g = 128'h00007CC6C0C060380C0606C67C000000; // S
         7'h45:   g = 128'h0000FEC0C0C0C0FCC0C0C0C0FE000000; // E
         7'h50:   g = 128'h0000FCC6C6C6FCC0C0C0C0C0C0000000; // P
         7'h41:   g = 128'h0000386CC6C6C6FEC6C6C6C6C6000000; // A
         7'h55:   g = 128'h0000C6C6C6C6C6C6C6C6C6C67C000000; // U
         7'h52:   g = 128'h0000FCC6C6C6FCD8CCCCC6C6C6000000; // R
         7'h44:   g = 128'h0000F8CCC6C6C6C6C6C6C6CCF8000000; // D
         7'h59:   g = 128'h0000C6C6C66C38181818181818000000; // Y
         default: g = '0;                                   // space and unused codes
      endcase
      return g[8*(15-int'(row)) +: 8];
   endfunction

endpackage

// File: rtl/ascii_rom.sv
// Synchronous 8x16 font ROM: data is valid one clock after addr.
module ascii_rom
   import pixel_msg_pkg::*;
(
   input  logic              clk,
   input  logic [ROM_AW-1:0] addr,
   output logic [ROM_DW-1:0] data
);

   logic [ROM_DW-1:0] data_d, data_q;

   // Look up the addressed glyph row
   always_comb begin
      data_d = glyph_row(addr[10:4], addr[3:0]);
   end

   // Registered read port
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/pixel_msg_anim.sv
// Animation control for pixel_msg_gen: IDLE/REVEAL/SHOW FSM, reveal counter,
// marching-border offset and (with PIXEL_MSG_BLINK_EN) the SHOW blink counter.
module pixel_msg_anim
   import pixel_msg_pkg::*;
#(
   parameter int N_CHARS       = 4,
   parameter int REVEAL_FRAMES = 8,
   parameter int MARCH_FRAMES  = 4,
   parameter int CHECKER_LOG2  = 4
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    msg_load,
   input  logic [1:0]              msg_sel,
   input  logic                    msg_clear,
   output logic [3:0]              shown,
   output logic [CHECKER_LOG2:0]   off,
   output logic [1:0]              msg,
   output logic                    text_vis,
   output logic                    revealing,
   output logic                    reveal_done
);

   localparam int RCW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
   localparam int MCW = (MARCH_FRAMES > 1) ? $clog2(MARCH_FRAMES) : 1;

   state_e                state_q, state_d;
   logic [3:0]            shown_q, shown_d;
   logic [RCW-1:0]        rcnt_q, rcnt_d;
   logic [1:0]            msg_q, msg_d;
   logic                  done_q, done_d;
   logic [MCW-1:0]        mcnt_q, mcnt_d;
   logic [CHECKER_LOG2:0] off_q, off_d;

   // Border march: counts every frame_tick in every state (load/clear do not touch it)
   always_comb begin
      mcnt_d = mcnt_q;
      off_d  = off_q;
      if (frame_tick) begin
         if (mcnt_q == MCW'(MARCH_FRAMES - 1)) begin
            mcnt_d = '0;
            off_d  = off_q + 1'b1;
         end else begin
            mcnt_d = mcnt_q + 1'b1;
         end
      end
   end

   // FSM next state: load beats clear, and a tick arriving with a load is ignored
   always_comb begin
      state_d = state_q;
      shown_d = shown_q;
      rcnt_d  = rcnt_q;
      msg_d   = msg_q;
      done_d  = 1'b0;
      if (msg_load) begin
         state_d = REVEAL;
         shown_d = '0;
         rcnt_d  = '0;
         msg_d   = msg_sel;
      end else if (msg_clear) begin
         state_d = IDLE;
         shown_d = '0;
      end else if (frame_tick && state_q == REVEAL) begin
         if (rcnt_q == RCW'(REVEAL_FRAMES - 1)) begin
            rcnt_d  = '0;
            shown_d = shown_q + 4'd1;
            if (shown_q + 4'd1 == 4'(N_CHARS)) begin
               state_d = SHOW;
               done_d  = 1'b1;
            end
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
   end

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shown_q <= '0;
         rcnt_q  <= '0;
         msg_q   <= '0;
         done_q  <= 1'b0;
         mcnt_q  <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         shown_q <= shown_d;
         rcnt_q  <= rcnt_d;
         msg_q   <= msg_d;
         done_q  <= done_d;
         mcnt_q  <= mcnt_d;
         off_q   <= off_d;
      end
   end

`ifdef PIXEL_MSG_BLINK_EN
   logic [5:0] blink_q, blink_d;

   // Blink phase: zero on SHOW entry, bit 5 hides the text for the second 32 ticks of each 64
   always_comb begin
      blink_d = blink_q;
      if (state_q != SHOW) blink_d = '0;
      else if (frame_tick) blink_d = blink_q + 6'd1;
   end

   // Blink counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) blink_q <= '0;
      else       blink_q <= blink_d;
   end

   assign text_vis = (state_q != SHOW) || !blink_q[5];
`else
   assign text_vis = 1'b1;
`endif

   assign shown       = shown_q;
   assign off         = off_q;
   assign msg         = msg_q;
   assign revealing   = (state_q == REVEAL);
   assign reveal_done = done_q;

endmodule

// File: rtl/pixel_msg_gen.sv
// Message banner pixel generator: scaled text over a marching checkered border.
// Two-stage pipeline (S0 decode + ROM read, S1 colour mux) -> rgb two clocks after x/y.
// Optional build macro PIXEL_MSG_BLINK_EN: text blinks every 32 frame_ticks in SHOW.
module pixel_msg_gen
   import pixel_msg_pkg::*;
#(
   parameter int          H_ACTIVE      = 800,
   parameter int          V_ACTIVE      = 600,
   parameter int          BORDER_SIZE   = 40,
   parameter int          CHECKER_LOG2  = 4,
   parameter int          SCALE_LOG2    = 2,
   parameter int          N_CHARS       = 4,
   parameter int          TEXT_X        = 336,
   parameter int          TEXT_Y        = 268,
   parameter int          REVEAL_FRAMES = 8,
   parameter int          MARCH_FRAMES  = 4,
   parameter logic [11:0] FG_RGB        = DEF_FG_RGB,
   parameter logic [11:0] BG_RGB        = DEF_BG_RGB,
   parameter logic [11:0] CHK_A         = DEF_CHK_A,
   parameter logic [11:0] CHK_B         = DEF_CHK_B
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        video_on,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        frame_tick,
   input  logic        msg_load,
   input  logic [1:0]  msg_sel,
   input  logic        msg_clear,
   output logic [11:0] rgb,
   output logic        revealing,
   output logic        reveal_done
);

   localparam int BOX_W = (N_CHARS * GLYPH_W) << SCALE_LOG2;
   localparam int BOX_H = GLYPH_H << SCALE_LOG2;

   logic [3:0]            shown;
   logic [CHECKER_LOG2:0] off;
   logic [1:0]            msg;
   logic                  text_vis;

   pixel_msg_anim #(
      .N_CHARS       (N_CHARS),
      .REVEAL_FRAMES (REVEAL_FRAMES),
      .MARCH_FRAMES  (MARCH_FRAMES),
      .CHECKER_LOG2  (CHECKER_LOG2)
   ) u_anim (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .msg_load    (msg_load),
      .msg_sel     (msg_sel),
      .msg_clear   (msg_clear),
      .shown       (shown),
      .off         (off),
      .msg         (msg),
      .text_vis    (text_vis),
      .revealing   (revealing),
      .reveal_done (reveal_done)
   );

   logic [10:0]       dx, dy;
   logic              in_box, in_brd, par;
   logic [2:0]        char_idx;
   logic [3:0]        row;
   logic [ROM_AW-1:0] rom_addr;
   logic [ROM_DW-1:0] rom_data;

   logic       vid_d, vid_q;
   logic       txt_d, txt_q;
   logic       brd_d, brd_q;
   logic       par_d, par_q;
   logic [2:0] col_d, col_q;
   logic [11:0] rgb_d, rgb_q;

   // S0 decode: text-box coordinates, region flags and checker parity for this pixel.
   // Reveal/blink visibility is sampled here so it stays aligned with the pixel.
   always_comb begin
      dx       = x - 11'(TEXT_X);
      dy       = y - 11'(TEXT_Y);
      in_box   = (x >= 11'(TEXT_X)) && (x < 11'(TEXT_X + BOX_W)) &&
                 (y >= 11'(TEXT_Y)) && (y < 11'(TEXT_Y + BOX_H));
      in_brd   = (x < 11'(BORDER_SIZE)) || (x >= 11'(H_ACTIVE - BORDER_SIZE)) ||
                 (y < 11'(BORDER_SIZE)) || (y >= 11'(V_ACTIVE - BORDER_SIZE));
      par      = 1'((x + 11'(off)) >> CHECKER_LOG2) ^ 1'(y >> CHECKER_LOG2);
      char_idx = 3'(dx >> (3 + SCALE_LOG2));
      row      = 4'(dy >> SCALE_LOG2);
      rom_addr = {msg_char(msg, char_idx), row};
      vid_d    = video_on;
      txt_d    = in_box && ((dx >> (3 + SCALE_LOG2)) < 11'(shown)) && text_vis;
      brd_d    = in_brd;
      par_d    = par;
      col_d    = 3'(dx >> SCALE_LOG2);
   end

   // The ROM registers the char/row address; its read lines up with the S0 flag register
   ascii_rom u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   // S0 register: flags and glyph column travel alongside the ROM read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vid_q <= 1'b0;
         txt_q <= 1'b0;
         brd_q <= 1'b0;
         par_q <= 1'b0;
         col_q <= '0;
      end else begin
         vid_q <= vid_d;
         txt_q <= txt_d;
         brd_q <= brd_d;
         par_q <= par_d;
         col_q <= col_d;
      end
   end

   // S1 colour mux: blanking, then lit glyph pixel, then border checker, then background
   always_comb begin
      rgb_d = BG_RGB;
      if (!vid_q)                          rgb_d = '0;
      else if (txt_q && rom_data[~col_q])  rgb_d = FG_RGB;
      else if (brd_q)                      rgb_d = par_q ? CHK_B : CHK_A;
   end

   // Output pixel register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rgb_q <= '0;
      else       rgb_q <= rgb_d;
   end

   assign rgb = rgb_q;

endmodule

// File: tb/tb_pixel_msg_gen.sv
// Randomised scoreboard bench for pixel_msg_gen against a frame-count reference model.
module tb_pixel_msg_gen;
   import pixel_msg_pkg::*;

   localparam int HA = 800, VA = 600, BS = 40, CL = 4, SC = 2, NC = 4;
   localparam int TX = 336, TY = 268, RF = 2, MF = 1;
   localparam int BW = (NC * 8) << SC;
   localparam int BH = 16 << SC;
   localparam logic [11:0] C_FG = 12'h00F, C_BG = 12'hFFF, C_A = 12'h0F0, C_B = 12'h000;

   logic        clk = 1'b0, reset = 1'b1;
   logic        video_on = 1'b0, frame_tick = 1'b0, msg_load = 1'b0, msg_clear = 1'b0;
   logic [10:0] x = '0, y = '0;
   logic [1:0]  msg_sel = '0;
   logic [11:0] rgb;
   logic        revealing, reveal_done;

   always #5 clk = ~clk;

   pixel_msg_gen #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .BORDER_SIZE(BS), .CHECKER_LOG2(CL), .SCALE_LOG2(SC),
      .N_CHARS(NC), .TEXT_X(TX), .TEXT_Y(TY), .REVEAL_FRAMES(RF), .MARCH_FRAMES(MF)
   ) dut (
      .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
      .frame_tick(frame_tick), .msg_load(msg_load), .msg_sel(msg_sel), .msg_clear(msg_clear),
      .rgb(rgb), .revealing(revealing), .reveal_done(reveal_done)
   );

   typedef struct { int stamp; logic [11:0] rgb; int px; int py; } exp_t;
   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0, n_err = 0;

   // Reference model: text is described by ticks counted since the last load
   bit m_active = 0;
   int m_rev_ticks = 0;
   int m_tot_ticks = 0;
   int m_msg = 0;
   bit m_done_due = 0;

   function automatic int m_shown();
      if (!m_active) return 0;
      return (m_rev_ticks / RF < NC) ? m_rev_ticks / RF : NC;
   endfunction

   function automatic bit m_visible();
`ifdef PIXEL_MSG_BLINK_EN
      if (m_shown() < NC) return 1'b1;
      return ((m_rev_ticks - NC * RF) / 32) % 2 == 0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [11:0] exp_rgb(input bit vo, input int px, input int py);
      int ci, col, row, off;
      logic [7:0] g;
      if (!vo) return 12'h000;
      if (px >= TX && px < TX + BW && py >= TY && py < TY + BH) begin
         ci  = (px - TX) / (8 << SC);
         col = ((px - TX) >> SC) % 8;
         row = ((py - TY) >> SC) % 16;
         g   = glyph_row(msg_char(2'(m_msg), 3'(ci)), 4'(row));
         if (ci < m_shown() && m_visible() && g[7 - col]) return C_FG;
      end
      if (px < BS || px >= HA - BS || py < BS || py >= VA - BS) begin
         off = (m_tot_ticks / MF) % 32;
         return ((((px + off) / 16) % 2) ^ ((py / 16) % 2)) ? C_B : C_A;
      end
      return C_BG;
   endfunction

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_rev_ticks = 0; m_tot_ticks = 0; m_msg = 0; m_done_due = 0;
   endtask

   // One pixel clock of stimulus: check control outputs, drive, log expected rgb, advance model
   task automatic step(input bit vo, input int px, input int py,
                       input bit tk, input bit ld, input int sel, input bit clr);
      bit was_rev;
      @(negedge clk);
      chk("revealing", {11'd0, revealing}, {11'd0, (m_active && m_shown() < NC)});
      chk("reveal_done", {11'd0, reveal_done}, {11'd0, m_done_due});
      m_done_due = 0;
      video_on = vo; x = 11'(px); y = 11'(py);
      frame_tick = tk; msg_load = ld; msg_sel = 2'(sel); msg_clear = clr;
      sb.push_back('{stamp: cyc, rgb: exp_rgb(vo, px, py), px: px, py: py});
      if (tk) m_tot_ticks++;
      if (ld) begin
         m_active = 1; m_rev_ticks = 0; m_msg = sel & 3;
      end else if (clr) begin
         m_active = 0; m_rev_ticks = 0;
      end else if (tk && m_active) begin
         was_rev = (m_shown() < NC);
         m_rev_ticks++;
         if (was_rev && m_shown() == NC) m_done_due = 1;
      end
   endtask

   task automatic pix(input int px, input int py);
      step(1, px, py, 0, 0, 0, 0);
   endtask

   task automatic tick();
      step(0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic box_probes(input int n);
      for (int i = 0; i < n; i++) pix(TX + int'($urandom_range(0, BW - 1)), TY + int'($urandom_range(0, BH - 1)));
   endtask

   task automatic rand_phase(input int n);
      int r, px, py;
      bit vo, tk, ld, clr;
      for (int i = 0; i < n; i++) begin
         r  = int'($urandom_range(0, 9));
         vo = ($urandom_range(0, 7) != 0);
         if (r < 4) begin
            px = TX + int'($urandom_range(0, BW - 1)); py = TY + int'($urandom_range(0, BH - 1));
         end else if (r < 7) begin
            px = int'($urandom_range(0, HA - 1)); py = int'($urandom_range(0, 2 * BS));
         end else begin
            px = int'($urandom_range(0, HA - 1)); py = int'($urandom_range(0, VA - 1));
         end
         if (!vo) begin
            px = int'($urandom_range(0, 2047)); py = int'($urandom_range(0, 2047));
         end
         tk  = ($urandom_range(0, 5) == 0);
         ld  = ($urandom_range(0, 59) == 0);
         clr = ($urandom_range(0, 89) == 0);
         step(vo, px, py, tk, ld, int'($urandom_range(0, 3)), clr);
      end
   endtask

   // Cycle stamp used to pair each expected entry with the edge that presents it
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: rgb appears two clocks after the stimulus that produced it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            while (sb.size() > 0 && sb[0].stamp + 2 <= cyc) begin
               e = sb.pop_front();
               n_cmp++;
               if (rgb !== e.rgb) begin
                  n_err++;
                  $display("FAIL rgb x=%0d y=%0d: got %h expected %h at t=%0t", e.px, e.py, rgb, e.rgb, $time);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk("por_rgb", rgb, 12'h000);
      chk("por_revealing", {11'd0, revealing}, 12'd0);
      chk("por_done", {11'd0, reveal_done}, 12'd0);
      @(negedge clk);
      reset = 1'b0;

      // Idle interior is background; checker squares with off=0
      pix(400, 300);
      pix(0, 0);
      pix(16, 0);
      pix(16, 16);
      pix(HA - 1, VA - 1);
      pix(BS - 1, 300);
      pix(BS, 300);
      step(0, 2000, 2000, 0, 0, 0, 0);

      // March: 31 ticks -> off=31, one more wraps to 0
      for (int i = 0; i < 31; i++) tick();
      pix(0, 0);
      pix(15, 0);
      tick();
      pix(0, 0);
      pix(16, 0);

      // Reveal "WIN!": W pixel (char 0) and '!' pixel (char 3) probed after every tick
      step(0, 0, 0, 0, 1, 0, 0);
      pix(TX, TY + 8);
      pix(TX + 108, TY + 8);
      for (int t = 1; t <= 8; t++) begin
         tick();
         pix(TX, TY + 8);
         pix(TX + 108, TY + 8);
         box_probes(4);
      end
      box_probes(10);

      // Load during REVEAL at shown=2 with a tick in the same cycle
      step(0, 0, 0, 0, 1, 1, 0);
      for (int t = 0; t < 4; t++) tick();
      box_probes(4);
      step(1, TX + 8, TY + 20, 1, 1, 3, 0);
      box_probes(4);
      tick();
      box_probes(4);
      tick();
      box_probes(6);
      // Load and clear together, then clear alone
      step(0, 0, 0, 0, 1, 2, 1);
      for (int t = 0; t < 3; t++) tick();
      box_probes(6);
      step(0, 0, 0, 0, 0, 0, 1);
      box_probes(4);

      // Reach SHOW, then hold through 70 ticks
      step(0, 0, 0, 0, 1, 0, 0);
      for (int t = 0; t < 8; t++) tick();
      for (int t = 0; t < 70; t++) begin
         pix(TX, TY + 8);
         box_probes(1);
         tick();
      end
      pix(TX, TY + 8);

      rand_phase(2500);

      // Mid-operation reset while revealing, on a non-edge time
      step(0, 0, 0, 0, 1, 3, 0);
      tick();
      pix(400, 300);
      pix(401, 300);
      pix(402, 300);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_rgb", rgb, 12'h000);
      chk("mid_rst_revealing", {11'd0, revealing}, 12'd0);
      sb.delete();
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pix(400, 300);
      pix(0, 0);
      box_probes(4);
      rand_phase(300);

      // Drain and confirm every expected pixel was presented
      step(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      chk("drain", 12'(sb.size()), 12'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
